// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: round-robin two-client byte-burst sequencer for the SPI_TOP master pins.
// Latency: req sampled -> gnt +1 cycle, tx_pop/SS low/SPE +2; SPIF rise sampled -> rx_valid next cycle.
// Backpressure: clients hold req level; a granted burst always runs its full byte count (watchdog abort with SPI_SEQ_TIMEOUT_EN).
module spi_xfer_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  input  logic [10:0] cfg0,
  input  logic [10:0] cfg1,
  input  logic [7:0]  tx0,
  input  logic [7:0]  tx1,
  output logic [1:0]  gnt,
  output logic [1:0]  tx_pop,
  output logic [7:0]  rx_data,
  output logic [1:0]  rx_valid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic [7:0]  spcr_out,
  output logic [7:0]  spibr_out,
  output logic        lsbfe_out,
  output logic [7:0]  spdr_out,
  output logic        ss_master_out,
  input  logic        spif_in,
  input  logic [7:0]  spdr_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic        owner;       // requester that owns the current burst
  logic        last_owner;  // round-robin pointer: requester granted last
  logic        pick;
  logic        spe;
  logic        cpol;
  logic        cpha;
  logic        spif_q;
  logic        spif_rise;
  logic [4:0]  remaining;
  logic [1:0]  owner_oh;
  logic [3:0]  owner_len;
  logic [10:0] owner_cfg;
  logic [7:0]  owner_tx;

  assign owner_oh  = owner ? 2'b10 : 2'b01;
  assign owner_len = owner ? len1 : len0;
  assign owner_cfg = owner ? cfg1 : cfg0;
  assign owner_tx  = owner ? tx1  : tx0;
  assign spif_rise = spif_in & ~spif_q;

  // SPCR image: SPE, MSTR fixed at 1, CPOL, CPHA; all other bits zero.
  assign spcr_out = {1'b0, spe, 1'b0, 1'b1, cpol, cpha, 2'b00};

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  logic            timed_out;
  logic [1:0]      err_q;
  logic            wd_expire;

  // Last XFER cycle of the watchdog window.
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;
`else
  // Watchdog limit only matters in the timeout build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign err            = 2'b00;
`endif

  // Winner selection: on contention the requester not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_owner;
    end else if (req[1]) begin
      pick = 1'b1;
    end
  end

  // Sequencer FSM; every output is a register updated on the edge leaving a state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      remaining     <= 5'd0;
      spe           <= 1'b0;
      cpol          <= 1'b0;
      cpha          <= 1'b0;
      spif_q        <= 1'b0;
      gnt           <= 2'b00;
      tx_pop        <= 2'b00;
      rx_valid      <= 2'b00;
      done          <= 2'b00;
      rx_data       <= 8'h00;
      busy          <= 1'b0;
      spibr_out     <= 8'h00;
      lsbfe_out     <= 1'b0;
      spdr_out      <= 8'h00;
      ss_master_out <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_cnt        <= '0;
      timed_out     <= 1'b0;
      err_q         <= 2'b00;
`endif
    end else begin
      spif_q   <= spif_in;
      gnt      <= 2'b00;
      tx_pop   <= 2'b00;
      rx_valid <= 2'b00;
      done     <= 2'b00;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q    <= 2'b00;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt       <= owner_oh;
          remaining <= (owner_len == 4'd0) ? 5'd16 : {1'b0, owner_len};
          lsbfe_out <= owner_cfg[10];
          cpol      <= owner_cfg[9];
          cpha      <= owner_cfg[8];
          spibr_out <= owner_cfg[7:0];
          state     <= LOAD;
        end
        LOAD: begin
          spdr_out      <= owner_tx;
          tx_pop        <= owner_oh;
          ss_master_out <= 1'b0;
          spe           <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
          wd_cnt        <= '0;
`endif
          state         <= XFER;
        end
        XFER: begin
          if (spif_rise) begin
            rx_data   <= spdr_in;
            rx_valid  <= owner_oh;
            remaining <= remaining - 5'd1;
            state     <= (remaining != 5'd1) ? LOAD : DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
          end else if (wd_expire) begin
            spe           <= 1'b0;
            ss_master_out <= 1'b1;
            timed_out     <= 1'b1;
            state         <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          spe           <= 1'b0;
          ss_master_out <= 1'b1;
          done          <= owner_oh;
          last_owner    <= owner;
          busy          <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_q         <= timed_out ? owner_oh : 2'b00;
          timed_out     <= 1'b0;
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Two-requester transaction sequencer in front of `SPI_TOP` (master mode).
- Arbitrates round-robin between two client ports and applies the winner's baud and mode settings to `SPI_TOP`.
- Streams 1–16 bytes per transaction through `SPDR`, returning each received byte to the winner.
- Drives `SS_master` around the whole burst.
- Sits between the system-side clients and the `SPCR_in` / `SPIBR_in` / `SPDR_From_user` / `SPIF` / `SS_master` pins of `SPI_TOP`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: `spif_in` watchdog limit in clk cycles; used only with `SPI_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester transaction request, level.
- `len0`, `len1`  in  4 each  byte count; value N means N bytes, 0 means 16.
- `cfg0`, `cfg1`  in  11 each  `{lsbfe, cpol, cpha, spibr[7:0]}`.
- `tx0`, `tx1`  in  8 each  next TX byte, valid whenever `req` is high.
- `gnt`  out  2  one-cycle one-hot grant pulse.
- `tx_pop`  out  2  one-cycle pulse: current `txN` consumed; present the next byte by the following LOAD.
- `rx_data`  out  8  received byte (shared by both requesters).
- `rx_valid`  out  2  one-cycle one-hot: `rx_data` is valid for that requester.
- `done`  out  2  one-cycle one-hot: transaction finished.
- `err`  out  2  one-cycle, coincident with `done`: transaction aborted.
- `busy`  out  1  high from GRANT through DONE.
- `spcr_out`  out  8  to `SPCR_in`: bit6 = SPE, bit4 = MSTR (always 1), bit3 = CPOL, bit2 = CPHA, other bits 0.
- `spibr_out`  out  8  to `SPIBR_in`.
- `lsbfe_out`  out  1  to `LSBFE`.
- `spdr_out`  out  8  to `SPDR_From_user`.
- `ss_master_out`  out  1  to `SS_master`, active-low.
- `spif_in`  in  1  from `SPIF`.
- `spdr_in`  in  8  received byte from `SPI_TOP`.

## Operation
States: IDLE, GRANT, LOAD, XFER, DONE (registered FSM, 3-bit encoding).

- **IDLE:** if any `req` is set, pick the winner.
  - When both are requesting, the requester not granted last wins.
  - After reset the pointer favours requester 0.
  - Go to GRANT.
- **GRANT:** pulse `gnt[w]` and latch `lenw` into a 5-bit `remaining` (0 → 16). Latch `cfgw` into `spibr_out`, `lsbfe_out`, CPOL and CPHA. Go to LOAD.
- **LOAD:** `spdr_out <= txw`, pulse `tx_pop[w]`, drive `ss_master_out` low, set SPE = 1. Go to XFER.
- **XFER:** wait for a rising edge of `spif_in`.
  - Only a 0→1 transition counts; a high level held for several cycles counts once.
  - On the edge: `rx_data <= spdr_in`, pulse `rx_valid[w]`, decrement `remaining`.
  - If `remaining` is now nonzero, go to LOAD; otherwise go to DONE.
- **DONE:** SPE = 0, `ss_master_out` = 1, pulse `done[w]`, update the round-robin pointer to `w`. Go to IDLE.
- Deasserting `req` mid-transaction is ignored; the transaction always completes its byte count.
- `cfgN` and `lenN` changes after GRANT do not affect the running transaction.
- A `req` raised during a transaction is serviced only after returning to IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `gnt`, `tx_pop`, `rx_valid`, `done`, `err` = 0; `busy` = 0; `rx_data` = 0.
  - `spcr_out` = 8'h10; `spibr_out` = 0; `lsbfe_out` = 0; `spdr_out` = 0; `ss_master_out` = 1.
  - FSM = IDLE; RR pointer = 1, so requester 0 wins first.
- `req` sampled high in IDLE → `gnt` at cycle +1, `tx_pop` and SS low at +2, SPE high at +2.
- `spif_in` edge sampled → `rx_valid` in the next cycle. The next byte's `tx_pop` follows 1 cycle later; the last byte's `done` follows 1 cycle later.
- Minimum gap between transactions: 1 IDLE cycle. SS stays high for at least 2 cycles (DONE → IDLE → GRANT).
- `rst` asserted at any time forces reset values immediately: the transfer is abandoned, with no `done` and no `err`.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - A counter runs while in XFER and clears on each LOAD.
  - If it reaches `TIMEOUT_CYCLES` without a `spif_in` edge: SPE = 0, SS high, go to DONE, and `err[w]` pulses with `done[w]`.
  - Remaining bytes are not popped.
- Not defined: no counter; XFER waits indefinitely; `err` is tied to 0.

## Test plan
- **Single byte:** `req` = 01, `len0` = 1, `tx0` = 8'hAA, `cfg0` = 11'h000, bench returns `spdr_in` = 8'h55 with an `spif_in` pulse.
  → `spcr_out` goes 8'h10 → 8'h50 → 8'h10, one `tx_pop[0]`, `rx_data` = 8'h55 with `rx_valid` = 01, `done` = 01, `ss_master_out` returns to 1.
- **Burst:** `len1` = 3, bytes 8'h01, 8'h02, 8'h03.
  → three `tx_pop[1]`, three `rx_valid[1]`, SS low continuously until DONE, `done` = 10.
- **Contention:** both `req` held with `len` = 1.
  → grants alternate 01, 10, 01, 10; first grant after reset is 01.
- **`len` = 0:** `len0` = 0.
  → exactly 16 `tx_pop[0]` and 16 `rx_valid[0]` before `done[0]`.
- **Held SPIF:** hold `spif_in` high for 5 cycles.
  → counts as one byte only.
- **Reset and timeout:**
  - Reset mid-burst: all outputs return to reset values and no `done` appears.
  - With `SPI_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, no SPIF: `err` = `done` = 01 after 16 XFER cycles, and SPE clears.
